// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation (cos/sin) and vectoring (magnitude/atan2),
// one micro-rotation per clock, valid/ready on both sides.
module cordic_engine #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 16,
  parameter int ITER  = 16,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] angle_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] angle_out,
  output logic             err
);

  localparam int IW = WIDTH + GUARD + 1;
  localparam int F  = FRAC + GUARD;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // K = prod 1/sqrt(1+2^-2i): K^2 built by exact-ish division, then integer sqrt (Q60 -> Q30).
  function automatic logic [63:0] calc_k(input int unsigned n, input int unsigned f);
    logic [63:0] k2, rem, root, bitv;
    k2 = 64'd1 << 60;
    for (int unsigned i = 0; i < n; i++) k2 = k2 - k2 / ((64'd1 << (2 * i)) + 64'd1);
    rem  = k2;
    root = '0;
    bitv = 64'd1 << 62;
    for (int unsigned b = 0; b < 32; b++) begin
      if (rem >= root + bitv) begin
        rem  = rem - root - bitv;
        root = (root >> 1) + bitv;
      end else begin
        root = root >> 1;
      end
      bitv = bitv >> 2;
    end
    calc_k = (root + (64'd1 << (29 - f))) >> (30 - f);
  endfunction

  // atan(2^-i) scaled by 2^32
  function automatic logic [31:0] atan_tab(input logic [4:0] idx);
    atan_tab = '0;
    case (idx)
      5'd0:  atan_tab = 32'd3373259426;
      5'd1:  atan_tab = 32'd1991351318;
      5'd2:  atan_tab = 32'd1052175346;
      5'd3:  atan_tab = 32'd534100635;
      5'd4:  atan_tab = 32'd268086748;
      5'd5:  atan_tab = 32'd134174063;
      5'd6:  atan_tab = 32'd67103403;
      5'd7:  atan_tab = 32'd33553749;
      5'd8:  atan_tab = 32'd16777131;
      5'd9:  atan_tab = 32'd8388597;
      5'd10: atan_tab = 32'd4194303;
      default: if (idx < 5'd24) atan_tab = 32'd1 << (6'd32 - {1'b0, idx});
    endcase
  endfunction

  function automatic logic signed [IW-1:0] atan_g(input logic [4:0] idx);
    logic [63:0] t;
    t = ({32'd0, atan_tab(idx)} + (64'd1 << (31 - F))) >> (32 - F);
    atan_g = IW'(t);
  endfunction

  function automatic logic signed [IW-1:0] ext(input logic [WIDTH-1:0] v);
    ext = {v[WIDTH-1], v, {GUARD{1'b0}}};
  endfunction

  localparam logic signed [IW-1:0]  K_INIT  = IW'(calc_k(ITER, F));
  localparam logic [63:0]           HP_F    = (64'd6746518852 + (64'd1 << (31 - FRAC))) >> (32 - FRAC);
  localparam logic signed [IW-1:0]  HALF_PI = IW'(HP_F << GUARD);
  localparam logic signed [WIDTH-1:0] VLIM  = WIDTH'(64'd1 << (FRAC - 1));
  localparam logic signed [IW:0]    RND     = (IW+1)'(64'd1 << (GUARD - 1));
  localparam logic signed [IW:0]    OMAX    = (IW+1)'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [WIDTH-1:0]      SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]      SMIN    = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] sat_out(input logic signed [IW-1:0] v);
    logic signed [IW:0] r;
    r = $signed({v[IW-1], v}) + RND;
    r = r >>> GUARD;
    if (r > OMAX)       sat_out = SMAX;
    else if (r < ~OMAX) sat_out = SMIN;
    else                sat_out = r[WIDTH-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d, err_q, err_d;
  logic signed [IW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d, acc_q, acc_d;
  logic [4:0]             i_q, i_d;
  logic                   out_valid_q, out_valid_d, err_out_q, err_out_d;
  logic [WIDTH-1:0]       x_out_q, x_out_d, y_out_q, y_out_d, ang_out_q, ang_out_d;

  logic signed [IW-1:0]   xs, ys, a_i, x_n, y_n, z_n, acc_n, ang_ext;
  logic signed [WIDTH-1:0] xin_s, yin_s;
  logic                   dpos, rot_err, vec_err;

  assign xin_s = x_in;
  assign yin_s = y_in;

  always_comb begin
    xs   = x_q >>> i_q;
    ys   = y_q >>> i_q;
    a_i  = atan_g(i_q);
    dpos = mode_q ? y_q[IW-1] : ~z_q[IW-1];
    if (dpos) begin
      x_n   = x_q - ys;
      y_n   = y_q + xs;
      z_n   = z_q - a_i;
      acc_n = acc_q + a_i;
    end else begin
      x_n   = x_q + ys;
      y_n   = y_q - xs;
      z_n   = z_q + a_i;
      acc_n = acc_q - a_i;
    end
    ang_ext = ext(angle_in);
    rot_err = (ang_ext > HALF_PI) || (ang_ext < -HALF_PI);
    vec_err = xin_s[WIDTH-1] || (xin_s > VLIM) || (yin_s > VLIM) || (yin_s < -VLIM);

    state_d     = state_q;
    mode_d      = mode_q;
    err_d       = err_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    acc_d       = acc_q;
    i_d         = i_q;
    out_valid_d = out_valid_q;
    err_out_d   = err_out_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    ang_out_d   = ang_out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          mode_d  = mode;
          i_d     = '0;
          acc_d   = '0;
          if (mode) begin
            x_d   = ext(x_in);
            y_d   = ext(y_in);
            z_d   = '0;
            err_d = vec_err;
          end else begin
            x_d   = K_INIT;
            y_d   = '0;
            z_d   = rot_err ? (ang_ext[IW-1] ? -HALF_PI : HALF_PI) : ang_ext;
            err_d = rot_err;
          end
        end
      end
      RUN: begin
        x_d   = x_n;
        y_d   = y_n;
        z_d   = z_n;
        acc_d = acc_n;
        i_d   = i_q + 5'd1;
        if (i_q == 5'(ITER - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          err_out_d   = err_q;
          x_out_d     = sat_out(x_n);
          y_out_d     = sat_out(y_n);
          // Vectoring drives y to zero, so the applied rotation is -atan2(y,x);
          // z started at 0 and carries +atan2 directly.
          ang_out_d   = sat_out(mode_q ? z_n : acc_n);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      out_valid_q <= 1'b0;
      err_out_q   <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      ang_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      out_valid_q <= out_valid_d;
      err_out_q   <= err_out_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      ang_out_q   <= ang_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign angle_out = ang_out_q;
  assign err       = err_out_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: default 18-bit instance plus a 26-bit/24-iteration instance.
module tb_cordic_engine;
  localparam int W = 18, IT = 16, WB = 26, ITB = 24;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, mode, out_valid, out_ready, err;
  logic [W-1:0] x_in, y_in, angle_in, x_out, y_out, angle_out;
  logic in_valid_b, in_ready_b, mode_b, out_valid_b, out_ready_b, err_b;
  logic [WB-1:0] x_in_b, y_in_b, angle_in_b, x_out_b, y_out_b, angle_out_b;

  cordic_engine #(.WIDTH(W), .FRAC(16), .ITER(IT), .GUARD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .out_valid(out_valid),
    .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .angle_out(angle_out), .err(err));

  cordic_engine #(.WIDTH(WB), .FRAC(24), .ITER(ITB), .GUARD(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .mode(mode_b),
    .x_in(x_in_b), .y_in(y_in_b), .angle_in(angle_in_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .x_out(x_out_b), .y_out(y_out_b), .angle_out(angle_out_b),
    .err(err_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int x, y, a;
    int tx, ty, ta;
    bit check;
    bit err;
    int acc_cyc;
  } exp_t;

  exp_t qa[$], qb[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input int id, input int act, input int want, input int tol);
    total++;
    if (act < want - tol || act > want + tol) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d, want %0d (+/-%0d)", nm, id, act, want, tol);
    end
  endtask

  function automatic exp_t mk(input int id, input int x, input int y, input int a,
                              input int tx, input int ty, input int ta, input bit check, input bit e);
    exp_t r;
    r.id = id; r.x = x; r.y = y; r.a = a;
    r.tx = tx; r.ty = ty; r.ta = ta;
    r.check = check; r.err = e; r.acc_cyc = 0;
    return r;
  endfunction

  task automatic check_res(input exp_t e, input bit first, input int iter,
                           input int xo, input int yo, input int ao, input bit er);
    if (first) chk("latency", e.id, cyc - e.acc_cyc, iter, 0);
    chk("err", e.id, int'(er), int'(e.err), 0);
    if (e.check) begin
      chk("x_out", e.id, xo, e.x, e.tx);
      chk("y_out", e.id, yo, e.y, e.ty);
      chk("angle_out", e.id, ao, e.a, e.ta);
    end
  endtask

  // Monitor for the default instance: checks on rising out_valid and again on the accepting cycle.
  initial begin
    exp_t cur;
    bit prev, have;
    prev = 0; have = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin prev = 0; have = 0; continue; end
      if (out_valid && !prev) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got out_valid=1, want no result pending");
        end else begin
          cur = qa.pop_front();
          have = 1;
          check_res(cur, 1, IT, int'($signed(x_out)), int'($signed(y_out)),
                    int'($signed(angle_out)), err);
        end
      end
      if (out_valid && out_ready && have) begin
        check_res(cur, 0, IT, int'($signed(x_out)), int'($signed(y_out)),
                  int'($signed(angle_out)), err);
        have = 0;
      end
      prev = out_valid;
    end
  end

  initial begin
    exp_t cur;
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin prev = 0; continue; end
      if (out_valid_b && !prev) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output_b: got out_valid=1, want no result pending");
        end else begin
          cur = qb.pop_front();
          check_res(cur, 1, ITB, int'($signed(x_out_b)), int'($signed(y_out_b)),
                    int'($signed(angle_out_b)), err_b);
        end
      end
      prev = out_valid_b;
    end
  end

  task automatic issue_a(input bit m, input int xi, input int yi, input int ang,
                         input bit push, input exp_t e);
    int n;
    exp_t e2;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_wait", e.id, int'(in_ready), 1, 0);
    mode = m; x_in = W'(xi); y_in = W'(yi); angle_in = W'(ang); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (push) begin e2 = e; e2.acc_cyc = cyc; qa.push_back(e2); end
  endtask

  task automatic issue_b(input int ang, input exp_t e);
    int n;
    exp_t e2;
    n = 0;
    @(negedge clk);
    while (!in_ready_b && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_wait_b", e.id, int'(in_ready_b), 1, 0);
    angle_in_b = WB'(ang); in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    e2 = e; e2.acc_cyc = cyc; qb.push_back(e2);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || out_valid || out_valid_b) && n < bound) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", 0, qa.size() + qb.size(), 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t e;
    in_valid = 0; mode = 0; x_in = '0; y_in = '0; angle_in = '0; out_ready = 1;
    in_valid_b = 0; mode_b = 0; x_in_b = '0; y_in_b = '0; angle_in_b = '0; out_ready_b = 1;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 0, int'(out_valid), 0, 0);
    chk("rst_in_ready", 0, int'(in_ready), 1, 0);
    chk("rst_x_out", 0, int'($signed(x_out)), 0, 0);
    chk("rst_y_out", 0, int'($signed(y_out)), 0, 0);
    chk("rst_angle_out", 0, int'($signed(angle_out)), 0, 0);
    chk("rst_err", 0, int'(err), 0, 0);
    rst_n = 1;

    issue_a(0, 0, 0, 0,       1, mk(1, 65536, 0, 0, 4, 4, 4, 1, 0));
    issue_a(0, 0, 0, -51472,  1, mk(2, 46341, -46341, -51472, 4, 4, 4, 1, 0));
    issue_a(0, 0, 0, 51472,   1, mk(3, 46341, 46341, 51472, 4, 4, 4, 1, 0));
    issue_a(0, 0, 0, 102944,  1, mk(4, 0, 65536, 102944, 4, 4, 4, 1, 0));
    issue_a(0, 0, 0, 110000,  1, mk(5, 0, 65536, 102944, 4, 4, 4, 1, 1));
    issue_a(0, 0, 0, -110000, 1, mk(6, 0, -65536, -102944, 4, 4, 4, 1, 1));
    issue_a(1, 32768, 32768, 0,  1, mk(7, 76312, 0, 51472, 6, 4, 4, 1, 0));
    issue_a(1, 32768, -32768, 0, 1, mk(8, 76312, 0, -51472, 6, 4, 4, 1, 0));
    issue_a(1, -100, 0, 0,       1, mk(9, 0, 0, 0, 0, 0, 0, 0, 1));
    issue_a(1, 1000, 32769, 0,   1, mk(10, 0, 0, 0, 0, 0, 0, 0, 1));
    drain(300);

    // Reset in the middle of an operation: no result may ever appear for it.
    issue_a(0, 0, 0, 51472, 0, mk(30, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 30, int'(out_valid), 0, 0);
    chk("midrst_x_out", 30, int'($signed(x_out)), 0, 0);
    chk("midrst_y_out", 30, int'($signed(y_out)), 0, 0);
    chk("midrst_angle_out", 30, int'($signed(angle_out)), 0, 0);
    chk("midrst_err", 30, int'(err), 0, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("midrst_in_ready", 30, int'(in_ready), 1, 0);
    repeat (IT + 4) @(negedge clk);
    chk("midrst_no_stale", 30, int'(out_valid), 0, 0);

    // Back-pressure: result held, a new request is not accepted until IDLE.
    out_ready = 0;
    issue_a(0, 0, 0, 0, 1, mk(11, 65536, 0, 0, 4, 4, 4, 1, 0));
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_wait", 11, int'(out_valid), 1, 0);
    mode = 0; angle_in = W'(-51472); in_valid = 1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 11, int'(in_ready), 0, 0);
      chk("bp_out_valid", 11, int'(out_valid), 1, 0);
    end
    e = mk(12, 46341, -46341, -51472, 4, 4, 4, 1, 0);
    e.acc_cyc = cyc + 2;
    qa.push_back(e);
    out_ready = 1;
    @(negedge clk);
    chk("bp_idle_valid", 12, int'(out_valid), 0, 0);
    chk("bp_idle_ready", 12, int'(in_ready), 1, 0);
    @(negedge clk);
    chk("bp_accepted", 12, int'(in_ready), 0, 0);
    in_valid = 0;
    drain(300);

    // Wide instance: WIDTH=26, FRAC=24, ITER=24.
    issue_b(8784530, mk(20, 14529495, 8388608, 8784530, 8, 8, 8, 1, 0));
    issue_b(0,       mk(21, 16777216, 0, 0, 8, 8, 8, 1, 0));
    drain(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
